// File: rtl/crc_ccitt_frame_checker_if.sv
// Byte-stream and result bundle for the CRC-CCITT frame checker.
// The checker connects through the slave modport; the byte source and
// the result consumer side connects through the master modport.
interface crc_ccitt_frame_checker_if #(
   parameter int LEN_W = 16
);
   // Byte stream from the deserializer
   logic             in_valid;
   logic             in_sof;
   logic             in_eof;
   logic [7:0]       in_data;
   logic             in_ready;

   // One report per frame towards the consumer
   logic             res_valid;
   logic             res_ok;
   logic [15:0]      res_crc;
   logic [15:0]      res_fcs;
   logic [LEN_W-1:0] res_len;
   logic             res_err_short;
   logic             res_err_long;
   logic             res_err_framing;

   modport master (
      output in_valid, in_sof, in_eof, in_data,
      input  in_ready,
      input  res_valid, res_ok, res_crc, res_fcs, res_len,
      input  res_err_short, res_err_long, res_err_framing
   );

   modport slave (
      input  in_valid, in_sof, in_eof, in_data,
      output in_ready,
      output res_valid, res_ok, res_crc, res_fcs, res_len,
      output res_err_short, res_err_long, res_err_framing
   );
endinterface

// File: rtl/crc_ccitt_frame_checker.sv
// Receive-side CRC-CCITT (poly 0x1021, MSB-first, no reflection, no final
// XOR) frame checker. The last two bytes of each sof/eof frame are the FCS,
// high byte first. A two-byte delay line holds back the newest bytes so that
// only payload bytes reach the CRC register; one report is issued per frame.
module crc_ccitt_frame_checker #(
   parameter logic [15:0] INIT_VALUE = 16'hFFFF,
   parameter int          LEN_W      = 16,
   parameter int          MAX_LEN    = 1024
) (
   input logic                      clk,
   input logic                      reset,
   crc_ccitt_frame_checker_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FRAME,
      S_REPORT
   } state_e;

   typedef struct packed {
      logic             ok;
      logic [15:0]      crc;
      logic [15:0]      fcs;
      logic [LEN_W-1:0] len;
      logic             err_short;
      logic             err_long;
      logic             err_framing;
   } result_t;

   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_TWO   = LEN_W'(2);
   localparam logic [LEN_W-1:0] LEN_SAT   = '1;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   // One byte through the serial CRC recurrence, MSB first.
   function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   state_e           state_q, state_d;
   logic [15:0]      crc_q, crc_d;
   logic [7:0]       d0_q, d0_d;
   logic [7:0]       d1_q, d1_d;
   logic [LEN_W-1:0] n_q, n_d;
   result_t          res_q, res_d;

   logic             in_ready;
   logic             xfer;
   logic [LEN_W-1:0] n_inc;
   logic [LEN_W-1:0] len_eof;
   logic [LEN_W-1:0] len_abort;
   logic [15:0]      crc_fold;
   logic [15:0]      fcs_eof;
   logic             err_long_eof;

   assign in_ready = (state_q != S_REPORT) && !reset;
   assign xfer     = bus.in_valid && in_ready;

   // The byte leaving d1 is payload only once two bytes sit behind it.
   assign n_inc        = (n_q == LEN_SAT) ? n_q : n_q + LEN_ONE;
   assign crc_fold     = (n_q >= LEN_TWO) ? crc_byte(crc_q, d1_q) : crc_q;
   assign fcs_eof      = {d0_q, bus.in_data};
   assign len_eof      = n_inc - LEN_TWO;
   assign len_abort    = (n_q >= LEN_TWO) ? n_q - LEN_TWO : '0;
   assign err_long_eof = (len_eof > MAX_LEN_L);

   // Next-state, delay line, CRC and result capture.
   always_comb begin
      // NOTE: every _d signal takes its hold value first, so no path through the case leaves it unassigned and no latch is inferred.
      state_d = state_q;
      crc_d   = crc_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      n_d     = n_q;
      res_d   = res_q;

      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               if (bus.in_sof) begin
                  crc_d = INIT_VALUE;
                  d0_d  = bus.in_data;
                  d1_d  = '0;
                  n_d   = LEN_ONE;
                  if (bus.in_eof) begin
                     state_d         = S_REPORT;
                     res_d           = '0;
                     res_d.crc       = INIT_VALUE;
                     res_d.fcs       = {8'h00, bus.in_data};
                     res_d.err_short = 1'b1;
                  end else begin
                     state_d = S_FRAME;
                  end
               end else begin
                  // Stray byte outside a frame: dropped and reported.
                  state_d           = S_REPORT;
                  res_d             = '0;
                  res_d.err_framing = 1'b1;
               end
            end
         end

         S_FRAME: begin
            if (xfer) begin
               if (bus.in_sof) begin
                  // New sof inside a frame aborts it; the sof byte is dropped.
                  state_d           = S_REPORT;
                  res_d             = '0;
                  res_d.crc         = crc_q;
                  res_d.fcs         = {d1_q, d0_q};
                  res_d.len         = len_abort;
                  res_d.err_framing = 1'b1;
               end else begin
                  crc_d = crc_fold;
                  d1_d  = d0_q;
                  d0_d  = bus.in_data;
                  n_d   = n_inc;
                  if (bus.in_eof) begin
                     state_d        = S_REPORT;
                     res_d          = '0;
                     res_d.crc      = crc_fold;
                     res_d.fcs      = fcs_eof;
                     res_d.len      = len_eof;
                     res_d.err_long = err_long_eof;
                     res_d.ok       = (crc_fold == fcs_eof) && !err_long_eof;
                  end
               end
            end
         end

         S_REPORT: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments make every register load from pre-edge values, independent of statement order.
      if (reset) begin
         state_q <= S_IDLE;
         crc_q   <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         n_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         n_q     <= n_d;
         res_q   <= res_d;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.res_valid       = (state_q == S_REPORT);
   assign bus.res_ok          = res_q.ok;
   assign bus.res_crc         = res_q.crc;
   assign bus.res_fcs         = res_q.fcs;
   assign bus.res_len         = res_q.len;
   assign bus.res_err_short   = res_q.err_short;
   assign bus.res_err_long    = res_q.err_long;
   assign bus.res_err_framing = res_q.err_framing;

endmodule

// File: tb/tb_crc_ccitt_frame_checker.sv
// Bench for crc_ccitt_frame_checker: two instances (INIT 0xFFFF and 0x0000)
// share one byte stream; a frame-level reference model predicts each report.
module tb_crc_ccitt_frame_checker;

   localparam int LEN_W   = 16;
   localparam int MAX_LEN = 1024;
   localparam int VEC_W   = 52;

   typedef struct {
      logic [VEC_W-1:0] vec;
      logic [VEC_W-1:0] mask;
      int               cyc;
   } rep_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_sof, in_eof;
   logic [7:0] in_data;

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   int stalls = 0;

   rep_t             exp_q [2][$];
   logic [VEC_W-1:0] obs_vec [2];
   logic             obs_valid [2];
   logic             obs_ready [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   crc_ccitt_frame_checker_if #(.LEN_W(LEN_W)) bif_a ();
   crc_ccitt_frame_checker_if #(.LEN_W(LEN_W)) bif_b ();

   assign bif_a.in_valid = in_valid;
   assign bif_a.in_sof   = in_sof;
   assign bif_a.in_eof   = in_eof;
   assign bif_a.in_data  = in_data;
   assign bif_b.in_valid = in_valid;
   assign bif_b.in_sof   = in_sof;
   assign bif_b.in_eof   = in_eof;
   assign bif_b.in_data  = in_data;

   crc_ccitt_frame_checker #(.INIT_VALUE(16'hFFFF), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bif_a)
   );

   crc_ccitt_frame_checker #(.INIT_VALUE(16'h0000), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bif_b)
   );

   assign obs_vec[0]   = {bif_a.res_ok, bif_a.res_crc, bif_a.res_fcs, bif_a.res_len,
                          bif_a.res_err_short, bif_a.res_err_long, bif_a.res_err_framing};
   assign obs_vec[1]   = {bif_b.res_ok, bif_b.res_crc, bif_b.res_fcs, bif_b.res_len,
                          bif_b.res_err_short, bif_b.res_err_long, bif_b.res_err_framing};
   assign obs_valid[0] = bif_a.res_valid;
   assign obs_valid[1] = bif_b.res_valid;
   assign obs_ready[0] = bif_a.in_ready;
   assign obs_ready[1] = bif_b.in_ready;

   // ---------------- reference model ----------------
   function automatic logic [15:0] init_of(input int k);
      return (k == 0) ? 16'hFFFF : 16'h0000;
   endfunction

   // Polynomial division of the message, MSB of each byte first.
   function automatic logic [15:0] crc16(input logic [15:0] init, input logic [7:0] msg[$]);
      logic [15:0] c;
      logic        top;
      c = init;
      foreach (msg[j]) begin
         for (int b = 7; b >= 0; b--) begin
            top = c[15] ^ msg[j][b];
            c   = c << 1;
            if (top) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   function automatic logic [VEC_W-1:0] pack(input logic ok, input logic [15:0] crc,
                                             input logic [15:0] fcs, input int len,
                                             input logic sh, input logic lg, input logic fr);
      return {ok, crc, fcs, LEN_W'(len), sh, lg, fr};
   endfunction

   // Expected report for a well-formed sof..eof frame (all bytes in order).
   function automatic rep_t model_frame(input logic [15:0] init, input logic [7:0] fr[$], input int t);
      rep_t        r;
      logic [7:0]  pay[$];
      logic [15:0] crc, fcs;
      int          n, len;
      logic        lg;
      n      = fr.size();
      r.cyc  = t;
      r.mask = '1;
      if (n < 2) begin
         r.vec = pack(1'b0, init, {8'h00, fr[0]}, 0, 1'b1, 1'b0, 1'b0);
         return r;
      end
      for (int j = 0; j < n - 2; j++) pay.push_back(fr[j]);
      crc   = crc16(init, pay);
      fcs   = {fr[n-2], fr[n-1]};
      len   = n - 2;
      lg    = (len > MAX_LEN);
      r.vec = pack((crc == fcs) && !lg, crc, fcs, len, 1'b0, lg, 1'b0);
      return r;
   endfunction

   // A stray byte outside a frame: only flags and length are defined.
   function automatic rep_t model_stray(input int t);
      rep_t r;
      r.cyc  = t;
      r.vec  = pack(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b1);
      r.mask = {1'b1, 32'h0, {LEN_W{1'b1}}, 3'b111};
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      rep_t e;
      for (int k = 0; k < 2; k++) begin
         if (obs_valid[k] === 1'b1) begin
            n_cmp++;
            if (exp_q[k].size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_report dut%0d cyc %0d: got %h, required no report", k, cyc, obs_vec[k]);
            end else begin
               e = exp_q[k].pop_front();
               if ((obs_vec[k] & e.mask) !== (e.vec & e.mask)) begin
                  n_bad++;
                  $display("FAIL report_fields dut%0d: got %h, required %h (mask %h)",
                           k, obs_vec[k], e.vec, e.mask);
               end
               n_cmp++;
               if (cyc !== e.cyc) begin
                  n_bad++;
                  $display("FAIL report_latency dut%0d: pulse at cycle %0d, required %0d", k, cyc, e.cyc);
               end
            end
         end
      end
   end

   // ---------------- drivers ----------------
   // All drivers start and end 1 time unit after a rising edge.
   task automatic drive_idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic s, input logic e, output int tcyc);
      int w;
      w        = 0;
      in_valid = 1'b1;
      in_sof   = s;
      in_eof   = e;
      in_data  = d;
      while (obs_ready[0] !== 1'b1 && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      stalls += w;
      if (w >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: in_ready low for %0d cycles, required high", w);
      end
      @(posedge clk);
      #1;
      tcyc = cyc;
   endtask

   task automatic send_frame(input logic [7:0] fr[$]);
      int t;
      t = 0;
      foreach (fr[j]) send_byte(fr[j], j == 0, j == fr.size() - 1, t);
      for (int k = 0; k < 2; k++) exp_q[k].push_back(model_frame(init_of(k), fr, t));
   endtask

   task automatic expect_drained(input string name);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (exp_q[k].size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing_reports dut%0d: %0d outstanding, required 0", name, k, exp_q[k].size());
            exp_q[k].delete();
         end
      end
   endtask

   function automatic void rand_frame(output logic [7:0] fr[$], input int plen, input int good_for);
      logic [7:0]  pay[$];
      logic [15:0] c;
      for (int j = 0; j < plen; j++) pay.push_back(8'($urandom));
      c  = (good_for >= 0) ? crc16(init_of(good_for), pay) : 16'($urandom);
      fr = pay;
      fr.push_back(c[15:8]);
      fr.push_back(c[7:0]);
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
      in_data  = 8'h00;
      #3;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs_ready[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready dut%0d: got %b, required 0", k, obs_ready[k]);
         end
         n_cmp++;
         if ({obs_valid[k], obs_vec[k]} !== '0) begin
            n_bad++;
            $display("FAIL reset_results dut%0d: got %h, required 0", k, {obs_valid[k], obs_vec[k]});
         end
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs_ready[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_ready dut%0d: got %b, required 1", k, obs_ready[k]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_vectors();
      logic [7:0] digits[$];
      logic [7:0] fr[$];
      digits = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      send_frame({8'h41, 8'hB9, 8'h15});
      drive_idle(2);
      fr = digits; fr.push_back(8'h29); fr.push_back(8'hB1);
      send_frame(fr);
      drive_idle(2);
      fr = digits; fr.push_back(8'h29); fr.push_back(8'hB0);
      send_frame(fr);
      drive_idle(2);
      send_frame({8'h41, 8'h58, 8'hE5});
      drive_idle(2);
      fr = digits; fr.push_back(8'h31); fr.push_back(8'hC3);
      send_frame(fr);
      drive_idle(2);
      send_frame({8'hFF, 8'hFF});
      drive_idle(2);
      send_frame({8'h00, 8'h00});
      drive_idle(2);
      expect_drained("vectors");
   endtask

   task automatic test_short();
      send_frame({8'h41});
      drive_idle(2);
      send_frame({8'($urandom)});
      send_frame({8'h41, 8'hB9, 8'h15});
      drive_idle(2);
      expect_drained("short");
   endtask

   task automatic test_framing();
      logic [7:0] b[5];
      logic [7:0] first[$];
      rep_t       r;
      int         t;
      foreach (b[j]) b[j] = 8'($urandom);
      send_byte(b[0], 1'b0, 1'b0, t);
      for (int k = 0; k < 2; k++) exp_q[k].push_back(model_stray(t));
      drive_idle(2);
      // sof on the fourth byte aborts the frame; the next plain byte is stray
      send_byte(b[0], 1'b1, 1'b0, t);
      send_byte(b[1], 1'b0, 1'b0, t);
      send_byte(b[2], 1'b0, 1'b0, t);
      send_byte(b[3], 1'b1, 1'b0, t);
      first = {b[0]};
      for (int k = 0; k < 2; k++) begin
         r.cyc  = t;
         r.mask = '1;
         r.vec  = pack(1'b0, crc16(init_of(k), first), {b[1], b[2]}, 1, 1'b0, 1'b0, 1'b1);
         exp_q[k].push_back(r);
      end
      send_byte(b[4], 1'b0, 1'b1, t);
      for (int k = 0; k < 2; k++) exp_q[k].push_back(model_stray(t));
      drive_idle(2);
      send_frame({8'h41, 8'h58, 8'hE5});
      drive_idle(2);
      expect_drained("framing");
   endtask

   task automatic test_back_to_back();
      logic [7:0] fr[$];
      int         nfr;
      nfr    = 6;
      stalls = 0;
      for (int f = 0; f < nfr; f++) begin
         rand_frame(fr, $urandom_range(0, 12), (f % 3 == 2) ? -1 : f % 2);
         send_frame(fr);
      end
      drive_idle(3);
      n_cmp++;
      if (stalls != nfr - 1) begin
         n_bad++;
         $display("FAIL back_to_back_stalls: got %0d stall cycles, required %0d", stalls, nfr - 1);
      end
      expect_drained("back_to_back");
   endtask

   task automatic test_reset_mid();
      int t;
      for (int j = 0; j < 5; j++) send_byte(8'($urandom), j == 0, 1'b0, t);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if ({obs_ready[k], obs_valid[k], obs_vec[k]} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_clear dut%0d: got %h, required 0",
                     k, {obs_ready[k], obs_valid[k], obs_vec[k]});
         end
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      send_frame({8'h41, 8'hB9, 8'h15});
      drive_idle(2);
      expect_drained("reset_mid");
   endtask

   task automatic test_long();
      logic [7:0] fr[$];
      rand_frame(fr, MAX_LEN + 1, 0);
      send_frame(fr);
      drive_idle(2);
      rand_frame(fr, MAX_LEN, 0);
      send_frame(fr);
      drive_idle(2);
      expect_drained("long");
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_short();
      test_framing();
      test_back_to_back();
      test_reset_mid();
      test_long();
      drive_idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
